if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register. Directly upstream of the ID-stage control decoder.
- Holds the PC and issues requests to instruction memory using a req/ready handshake.
- Buffers the returned word and presents decoded fields (op, func, rt, rs, rd, imm16) to ID.
- Honours hazard-unit stalls and EX-stage redirects (taken branch, j/jal, jr/jalr). No delay slot: a redirect squashes the instruction in IF/ID.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID when squashed (sll $0,$0,0).

Ports:
- clk  in  1  Single system clock. All state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- stall_i  in  1  Hazard-unit stall (load-use). Freezes PC and IF/ID.
- redirect_i  in  1  EX-stage control-flow change. Has priority over stall_i.
- redirect_pc_i  in  32  Target PC for the redirect.
- imem_req_o  out  1  Instruction memory request.
- imem_addr_o  out  32  Fetch address (always equals pc).
- imem_ready_i  in  1  One-cycle response strobe. imem_rdata_i is valid in the same cycle.
- imem_rdata_i  in  32  Instruction word.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_instr_o  out  32  Latched instruction word.
- ifid_pc_o  out  32  PC of the latched instruction.
- ifid_pc4_o  out  32  ifid_pc_o + 4, used by jal/jalr link and branch targets.
- op_o  out  6  ifid_instr_o[31:26]
- rs_o  out  5  ifid_instr_o[25:21]
- rt_o  out  5  ifid_instr_o[20:16]
- rd_o  out  5  ifid_instr_o[15:11]
- func_o  out  6  ifid_instr_o[5:0]
- imm16_o  out  16  ifid_instr_o[15:0]

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - ifid_valid_o=0, ifid_instr_o=NOP_INSTR, ifid_pc_o=0, ifid_pc4_o=0.
  - Buffer register cleared, buf_valid=0.
  - imem_req_o=0 while rst_n is low.
  - Reset released mid-request: the request restarts from RESET_PC.
- Field outputs (op_o through imm16_o) are pure slices of ifid_instr_o. They are 0 after reset and after a squash.
- FETCH state:
  - imem_req_o=1, imem_addr_o=pc. Address is held stable until imem_ready_i, except when a redirect occurs.
  - imem_ready_i=1 and stall_i=0: IF/ID <= {1, rdata, pc, pc+4}; pc <= pc+4. Stay in FETCH.
  - imem_ready_i=1 and stall_i=1: capture rdata and pc into the buffer. IF/ID holds. Go to HOLD.
  - imem_ready_i=0: keep requesting. IF/ID holds if stall_i=1. If stall_i=0, IF/ID <= bubble (valid=0, instr=NOP_INSTR).
- HOLD state:
  - imem_req_o=0.
  - stall_i=1: everything holds.
  - stall_i=0: IF/ID <= buffer contents; pc <= pc+4; buf_valid <= 0; go to FETCH.
- Redirect (any state, highest priority after reset):
  - pc <= {redirect_pc_i[31:2], 2'b00}.
  - IF/ID <= bubble; buffer discarded; state <= FETCH.
  - Any imem response in the same cycle is discarded.
  - The IF/ID squash also applies when stall_i=1.
- Throughput and latency:
  - Zero-wait memory (ready in the same cycle as req) gives one instruction per cycle.
  - Word fetched at edge N is visible in IF/ID after edge N.
  - First valid IF/ID occurs on the first edge after reset with ready=1.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). PC bits [1:0] are always 0.
- Stall held indefinitely: pc and IF/ID are stable and at most one word is buffered. No request is issued in HOLD.

Test Plan:
- Reset, then zero-wait imem returning 32'h2408_0005 at 0x3000 and 32'h0109_5021 at 0x3004 -> IF/ID shows pc 0x3000 then 0x3004 on consecutive cycles. op_o=6'b001001, rt_o=8 for the first word.
- Stall asserted for 3 cycles while ready=1 at 0x3008 -> IF/ID and pc frozen; HOLD entered and imem_req_o=0. After release, IF/ID shows pc 0x3008, then fetching resumes at 0x300C.
- redirect_i with redirect_pc_i=0x3040 while stall_i=1 and ready=1 -> next cycle ifid_valid_o=0, instr=0, imem_addr_o=0x3040. The returned word is not latched.
- imem_ready_i low for 2 cycles at 0x3010 -> imem_addr_o stays at 0x3010 and IF/ID shows bubbles. On ready, the word is latched with ifid_pc4_o=0x3014.
- rst_n pulsed low mid-HOLD -> all outputs return to reset values immediately (asynchronous). After release, the fetch restarts at 0x3000.
- Redirect to 0xFFFF_FFFC, then a zero-wait fetch -> ifid_pc4_o=0x0000_0000 and the next fetch address is 0x0000_0000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches from instruction memory with a req/ready handshake, buffers a word
// returned during a stall, and presents the decoded fields to ID.
// A redirect from EX squashes IF/ID (no delay slot).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [5:0]  op_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  func_o,
  output logic [15:0] imm16_o
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic        buf_valid_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;

  logic [31:0] pc_inc;
  logic [31:0] redir_pc;

  // Next sequential fetch address and word-aligned redirect target.
  always_comb begin
    pc_inc   = pc_q + 32'd4;
    redir_pc = redirect_pc_i & 32'hFFFF_FFFC;
  end

  // Fetch FSM: redirect beats stall; HOLD parks one word while ID is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= 32'h0;
      buf_pc_q     <= 32'h0;
    end else if (redirect_i) begin
      // Squash IF/ID even under stall; any response this cycle is dropped.
      state_q      <= FETCH;
      pc_q         <= redir_pc;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      buf_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready_i) begin
            if (!stall_i) begin
              ifid_valid_q <= 1'b1;
              ifid_instr_q <= imem_rdata_i;
              ifid_pc_q    <= pc_q;
              ifid_pc4_q   <= pc_inc;
              pc_q         <= pc_inc;
            end else begin
              // pc stays on the buffered word's address until it drains.
              buf_valid_q <= 1'b1;
              buf_instr_q <= imem_rdata_i;
              buf_pc_q    <= pc_q;
              state_q     <= HOLD;
            end
          end else if (!stall_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_valid_q <= buf_valid_q;
            ifid_instr_q <= buf_instr_q;
            ifid_pc_q    <= buf_pc_q;
            ifid_pc4_q   <= buf_pc_q + 32'd4;
            pc_q         <= pc_inc;
            buf_valid_q  <= 1'b0;
            state_q      <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Request is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    imem_req_o  = rst_n && (state_q == FETCH);
    imem_addr_o = pc_q;
  end

  // IF/ID outputs and decoded field slices.
  always_comb begin
    ifid_valid_o = ifid_valid_q;
    ifid_instr_o = ifid_instr_q;
    ifid_pc_o    = ifid_pc_q;
    ifid_pc4_o   = ifid_pc4_q;
    op_o         = ifid_instr_q[31:26];
    rs_o         = ifid_instr_q[25:21];
    rt_o         = ifid_instr_q[20:16];
    rd_o         = ifid_instr_q[15:11];
    func_o       = ifid_instr_q[5:0];
    imm16_o      = ifid_instr_q[15:0];
  end

endmodule
